// File: rtl/azadi_jtag_pkg.sv
// Shared types and constants for the Azadi JTAG master.
// The INIT state exists only when AZADI_JTAG_RESET_SEQ_EN is defined.
package azadi_jtag_pkg;

  localparam int DefaultMaxLen   = 64;
  localparam int DefaultClkDiv   = 4;
  localparam int JtagResetSeqLen = 5;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    RESP
`ifdef AZADI_JTAG_RESET_SEQ_EN
    , INIT
`endif
  } jtag_mst_state_e;

endpackage

// File: rtl/azadi_jtag_clkdiv.sv
// TCK phase timer: counts ClkDiv system cycles per half period and pulses
// phase_end in the last cycle of each phase.
module azadi_jtag_clkdiv #(
  parameter int ClkDiv = 4
) (
  input  logic clock,
  input  logic reset_ni,
  input  logic start,
  input  logic en,
  output logic phase_end
);

  localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  logic [CntW-1:0] cnt_q;

  assign phase_end = en && (cnt_q == CntW'(ClkDiv - 1));

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni)      cnt_q <= '0;
    else if (start)     cnt_q <= '0;
    else if (phase_end) cnt_q <= '0;
    else if (en)        cnt_q <= cnt_q + CntW'(1);
  end

endmodule

// File: rtl/azadi_jtag_master.sv
// Command-driven JTAG master: shifts per-bit TMS/TDI vectors, captures TDO.
// Define AZADI_JTAG_RESET_SEQ_EN to run a 5-bit TMS=1 TAP reset after reset.
module azadi_jtag_master
  import azadi_jtag_pkg::*;
#(
  parameter int MaxLen = DefaultMaxLen,
  parameter int ClkDiv = DefaultClkDiv,
  parameter int LenW   = $clog2(MaxLen + 1)
) (
  input  logic              clock,
  input  logic              reset_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_tms_i,
  input  logic [MaxLen-1:0] cmd_tdi_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_tdo_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i,
  output logic              jtag_trst_no,
  output logic              busy_o
);

  localparam int IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  jtag_mst_state_e state_q, state_d;

  logic [LenW-1:0]   len_q, len_clamp;
  logic [IdxW-1:0]   idx_q;
  logic [MaxLen-1:0] tms_sr, tdi_sr, tdo_q;
  logic              tck_q, tms_q, tdi_q, trst_q, rsp_valid_q, init_q;
  logic              accept, load_init, bit_end, last_bit, rsp_hs, phase_end;

  assign len_clamp = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
  assign last_bit  = (LenW'(idx_q) == len_q - LenW'(1));
  assign rsp_hs    = rsp_valid_q && rsp_ready_i;

  azadi_jtag_clkdiv #(.ClkDiv(ClkDiv)) u_clkdiv (
    .clock     (clock),
    .reset_ni  (reset_ni),
    .start     (accept || load_init),
    .en        ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)),
    .phase_end (phase_end)
  );

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
`ifdef AZADI_JTAG_RESET_SEQ_EN
      state_q <= INIT;
`else
      state_q <= IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    load_init = 1'b0;
    bit_end   = 1'b0;
    unique case (state_q)
`ifdef AZADI_JTAG_RESET_SEQ_EN
      INIT: if (trst_q) begin
        load_init = 1'b1;
        state_d   = SHIFT_LO;
      end
`endif
      IDLE: if (cmd_valid_i && cmd_ready_o) begin
        accept  = 1'b1;
        state_d = (cmd_len_i == '0) ? RESP : SHIFT_LO;
      end
      SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
      SHIFT_HI: if (phase_end) begin
        bit_end = 1'b1;
        if (!last_bit)   state_d = SHIFT_LO;
        else if (init_q) state_d = IDLE;
        else             state_d = RESP;
      end
      RESP: if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      len_q       <= '0;
      idx_q       <= '0;
      tms_sr      <= '0;
      tdi_sr      <= '0;
      tdo_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      trst_q      <= 1'b1;
      tck_q       <= (state_d == SHIFT_HI);
      rsp_valid_q <= (state_q == RESP) && !rsp_hs;
      if (accept) begin
        len_q  <= len_clamp;
        idx_q  <= '0;
        tdo_q  <= '0;
        tms_sr <= cmd_tms_i >> 1;
        tdi_sr <= cmd_tdi_i >> 1;
        // a zero-length command leaves the pins at their last driven values
        if (cmd_len_i != '0) begin
          tms_q <= cmd_tms_i[0];
          tdi_q <= cmd_tdi_i[0];
        end
      end
      if (load_init) begin
        len_q  <= LenW'(JtagResetSeqLen);
        idx_q  <= '0;
        tms_sr <= '1;
        tdi_sr <= '0;
        tms_q  <= 1'b1;
        tdi_q  <= 1'b0;
        init_q <= 1'b1;
      end
      if (bit_end) begin
        tdo_q[idx_q] <= jtag_tdo_i;
        if (last_bit) begin
          init_q <= 1'b0;
        end else begin
          idx_q  <= idx_q + IdxW'(1);
          tms_q  <= tms_sr[0];
          tdi_q  <= tdi_sr[0];
          tms_sr <= tms_sr >> 1;
          tdi_sr <= tdi_sr >> 1;
        end
      end
    end
  end

  assign cmd_ready_o  = (state_q == IDLE) && trst_q;
  assign busy_o       = (state_q != IDLE) && trst_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_tdo_o    = tdo_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

endmodule

// File: tb/tb_azadi_jtag_master.sv
// Directed bench for azadi_jtag_master (ClkDiv=2, MaxLen=64), TDO looped to TDI.
module tb_azadi_jtag_master;

  localparam int MaxLen = 64;
  localparam int ClkDiv = 2;
  localparam int LenW   = 7;

  logic              clock = 1'b0;
  logic              reset_ni;
  logic              cmd_valid_i, cmd_ready_o;
  logic [LenW-1:0]   cmd_len_i;
  logic [MaxLen-1:0] cmd_tms_i, cmd_tdi_i;
  logic              rsp_valid_o, rsp_ready_i;
  logic [MaxLen-1:0] rsp_tdo_o;
  logic              jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_i, jtag_trst_no, busy_o;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  int hi_cnt, tms_and, r0, cyc, n;
  logic vld_seen;

  azadi_jtag_master #(.MaxLen(MaxLen), .ClkDiv(ClkDiv)) dut (
    .clock        (clock),
    .reset_ni     (reset_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .cmd_tms_i    (cmd_tms_i),
    .cmd_tdi_i    (cmd_tdi_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_tdo_o    (rsp_tdo_o),
    .jtag_tck_o   (jtag_tck_o),
    .jtag_tms_o   (jtag_tms_o),
    .jtag_tdi_o   (jtag_tdi_o),
    .jtag_tdo_i   (jtag_tdo_i),
    .jtag_trst_no (jtag_trst_no),
    .busy_o       (busy_o)
  );

  assign jtag_tdo_i = jtag_tdi_o;

  always #5 clock = ~clock;
  always @(posedge jtag_tck_o) rises++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic accept_cmd(input int len, input logic [63:0] tms, input logic [63:0] tdi);
    int w = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LenW'(len);
    cmd_tms_i   = tms;
    cmd_tdi_i   = tdi;
    while (!cmd_ready_o && w < 100) begin
      tick();
      w++;
    end
    chk("cmd_ready_before_accept", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    hi_cnt = 0;
    tms_and = 1;
    while (!rsp_valid_o && c < 1000) begin
      tick();
      c++;
      if (jtag_tck_o) hi_cnt++;
      if (!jtag_tms_o) tms_and = 0;
    end
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid_o, 1'b0);
    chk("cmd_ready_after_hs", cmd_ready_o, 1'b1);
  endtask

  initial begin
    reset_ni = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = '0;
    cmd_tms_i = '0; cmd_tdi_i = '0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tck", jtag_tck_o, 1'b0);
    chk("rst_tms", jtag_tms_o, 1'b1);
    chk("rst_tdi", jtag_tdi_o, 1'b0);
    chk("rst_trst", jtag_trst_no, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_tdo", rsp_tdo_o, 64'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cmd_ready", cmd_ready_o, 1'b0);

    @(negedge clock);
    reset_ni = 1'b1;
    r0 = rises;
    tick();
    chk("rel_trst", jtag_trst_no, 1'b1);
    chk("rel_cmd_ready", cmd_ready_o, 1'b1);
    chk("rel_tms", jtag_tms_o, 1'b1);
    chk("rel_tdi", jtag_tdi_o, 1'b0);
    tick();
    chk("rel_no_tck", rises - r0, 0);

    // TAP reset: 5 pulses, 2 cycles high each, response 21 cycles after accept
    r0 = rises;
    accept_cmd(5, 64'h1F, 64'h0);
    chk("tap_cmd_ready_low", cmd_ready_o, 1'b0);
    chk("tap_busy", busy_o, 1'b1);
    chk("tap_tms0", jtag_tms_o, 1'b1);
    wait_rsp(cyc);
    chk("tap_latency", cyc, 21);
    chk("tap_pulses", rises - r0, 5);
    chk("tap_high_cycles", hi_cnt, 10);
    chk("tap_tms_all_one", tms_and, 1);
    chk("tap_rsp", rsp_tdo_o, 64'h0);
    handshake();

    // loopback capture of 8'hA5
    accept_cmd(8, 64'h0, 64'hA5);
    chk("lb_bit0_tdi", jtag_tdi_o, 1'b1);
    chk("lb_tck_low0", jtag_tck_o, 1'b0);
    tick();
    chk("lb_tck_low1", jtag_tck_o, 1'b0);
    tick();
    chk("lb_tck_rise", jtag_tck_o, 1'b1);
    wait_rsp(cyc);
    chk("lb_latency", cyc, 31);
    chk("lb_rsp", rsp_tdo_o, 64'hA5);
    handshake();

    // zero length
    r0 = rises;
    accept_cmd(0, 64'hFFFF, 64'hDEAD);
    wait_rsp(cyc);
    chk("zero_latency", cyc, 1);
    chk("zero_rsp", rsp_tdo_o, 64'h0);
    chk("zero_no_tck", rises - r0, 0);
    handshake();

    // length 70 clamps to 64
    r0 = rises;
    accept_cmd(70, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_rsp(cyc);
    chk("clamp_latency", cyc, 257);
    chk("clamp_pulses", rises - r0, 64);
    chk("clamp_rsp", rsp_tdo_o, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake();

    // backpressure with a second command queued
    accept_cmd(3, 64'h0, 64'h6);
    wait_rsp(cyc);
    chk("bp_latency", cyc, 13);
    cmd_valid_i = 1'b1; cmd_len_i = LenW'(4); cmd_tms_i = 64'h0; cmd_tdi_i = 64'h9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", rsp_valid_o, 1'b1);
      chk("bp_hold_tdo", rsp_tdo_o, 64'h6);
      chk("bp_hold_cmd_ready", cmd_ready_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("bp_hs_valid_low", rsp_valid_o, 1'b0);
    chk("bp_ready_after_hs", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    chk("bp_second_busy", busy_o, 1'b1);
    chk("bp_second_bit0", jtag_tdi_o, 1'b1);
    wait_rsp(cyc);
    chk("bp_second_latency", cyc, 17);
    chk("bp_second_rsp", rsp_tdo_o, 64'h9);
    handshake();

    // reset during the high phase of bit 3
    accept_cmd(8, 64'h0, 64'hFF);
    repeat (15) tick();
    chk("mid_tck_high", jtag_tck_o, 1'b1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_tck", jtag_tck_o, 1'b0);
    chk("mid_rst_tms", jtag_tms_o, 1'b1);
    chk("mid_rst_tdi", jtag_tdi_o, 1'b0);
    chk("mid_rst_trst", jtag_trst_no, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_rsp_tdo", rsp_tdo_o, 64'h0);
    @(negedge clock);
    reset_ni = 1'b1;
    vld_seen = 1'b0;
    r0 = rises;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid_o) vld_seen = 1'b1;
    end
    chk("mid_no_response", vld_seen, 1'b0);
    chk("mid_cmd_ready", cmd_ready_o, 1'b1);
    chk("mid_no_tck_after", rises - r0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
